// File: rtl/bram_sp_arb.sv
// Two-requester round-robin arbiter in front of a single-port BRAM.
// Accepts one request per cycle, tracks reads through a 2-stage pipeline, and routes
// the read data back to the requester that issued the read, two cycles after acceptance.
module bram_sp_arb #(
  parameter int unsigned RAM_DATA_WIDTH = 32,
  parameter int unsigned RAM_ADDR_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  // Requester A
  input  logic                      a_valid,
  input  logic                      a_wr,
  input  logic [RAM_ADDR_WIDTH-1:0] a_addr,
  input  logic [RAM_DATA_WIDTH-1:0] a_data,
  output logic                      a_ready,
  output logic                      a_rsp_valid,
  output logic [RAM_DATA_WIDTH-1:0] a_rsp_data,
  // Requester B
  input  logic                      b_valid,
  input  logic                      b_wr,
  input  logic [RAM_ADDR_WIDTH-1:0] b_addr,
  input  logic [RAM_DATA_WIDTH-1:0] b_data,
  output logic                      b_ready,
  output logic                      b_rsp_valid,
  output logic [RAM_DATA_WIDTH-1:0] b_rsp_data,
  // BRAM command / read data
  output logic                      ram_wr,
  output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
  output logic [RAM_DATA_WIDTH-1:0] ram_din,
  input  logic [RAM_DATA_WIDTH-1:0] ram_dout,
  // Contention statistics
  output logic [15:0]               conflict_cnt
);

  localparam logic PortA = 1'b0;
  localparam logic PortB = 1'b1;

  // Arbitration state: port granted on the most recent transfer
  logic                      r_last_grant;

  // Read-tracking pipeline: valid bit plus owning port per stage
  logic                      r_p1_vld;
  logic                      r_p1_id;
  logic                      r_p2_vld;
  logic                      r_p2_id;

  // Response data and idle-cycle command hold registers
  logic [RAM_DATA_WIDTH-1:0] r_a_rsp_data;
  logic [RAM_DATA_WIDTH-1:0] r_b_rsp_data;
  logic [RAM_ADDR_WIDTH-1:0] r_addr_hold;
  logic [RAM_DATA_WIDTH-1:0] r_din_hold;
  logic [15:0]               r_conflict_cnt;

  // Grant / selected-command wires
  logic                      w_gnt_a;
  logic                      w_gnt_b;
  logic                      w_xfer;
  logic                      w_xfer_out;
  logic                      w_sel_wr;
  logic [RAM_ADDR_WIDTH-1:0] w_sel_addr;
  logic [RAM_DATA_WIDTH-1:0] w_sel_data;
  logic                      w_contend;

  // Round-robin grant: a lone requester wins, on contention the port not granted last wins
  always_comb begin
    w_contend  = a_valid & b_valid;
    w_gnt_a    = a_valid & (~b_valid | (r_last_grant == PortB));
    w_gnt_b    = b_valid & (~a_valid | (r_last_grant == PortA));
    w_xfer     = w_gnt_a | w_gnt_b;
    // Outputs are forced quiet while reset is held; state is already held by the async clear
    w_xfer_out = w_xfer & rst_n;
    w_sel_wr   = w_gnt_b ? b_wr   : a_wr;
    w_sel_addr = w_gnt_b ? b_addr : a_addr;
    w_sel_data = w_gnt_b ? b_data : a_data;
  end

  // BRAM command: pass the granted request through, otherwise replay the last one without a write
  always_comb begin
    a_ready  = w_gnt_a & rst_n;
    b_ready  = w_gnt_b & rst_n;
    ram_wr   = w_xfer_out & w_sel_wr;
    ram_addr = w_xfer_out ? w_sel_addr : r_addr_hold;
    ram_din  = w_xfer_out ? w_sel_data : r_din_hold;
  end

  // Last-grant tracking and command hold registers, updated on every transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= PortB;
      r_addr_hold  <= '0;
      r_din_hold   <= '0;
    end else if (w_xfer) begin
      r_last_grant <= w_gnt_b ? PortB : PortA;
      r_addr_hold  <= w_sel_addr;
      r_din_hold   <= w_sel_data;
    end
  end

  // Read pipeline: stage 1 lines up with the BRAM address sample, stage 2 with the response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p1_vld <= 1'b0;
      r_p1_id  <= PortA;
      r_p2_vld <= 1'b0;
      r_p2_id  <= PortA;
    end else begin
      r_p1_vld <= w_xfer & ~w_sel_wr;
      r_p1_id  <= w_gnt_b ? PortB : PortA;
      r_p2_vld <= r_p1_vld;
      r_p2_id  <= r_p1_id;
    end
  end

  // Capture BRAM read data into the owning port's response register; hold otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_rsp_data <= '0;
      r_b_rsp_data <= '0;
    end else if (r_p1_vld) begin
      if (r_p1_id == PortA) begin
        r_a_rsp_data <= ram_dout;
      end else begin
        r_b_rsp_data <= ram_dout;
      end
    end
  end

  // Saturating count of cycles where both requesters are valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_conflict_cnt <= '0;
    end else if (w_contend && (r_conflict_cnt != 16'hFFFF)) begin
      r_conflict_cnt <= r_conflict_cnt + 16'd1;
    end
  end

  // Response outputs: stage 2 valid routed by port id
  always_comb begin
    a_rsp_valid  = r_p2_vld & (r_p2_id == PortA);
    b_rsp_valid  = r_p2_vld & (r_p2_id == PortB);
    a_rsp_data   = r_a_rsp_data;
    b_rsp_data   = r_b_rsp_data;
    conflict_cnt = r_conflict_cnt;
  end

endmodule
